// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational 64-word imem between fetch (port 0) and debug/loader (port 1).
// Define IMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority with a starvation guard.
module imem_arbiter #(
    parameter int N      = 32,
    parameter int MAXRUN = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0,
    input  logic [5:0]   addr0,
    output logic         gnt0,
    output logic         rvalid0,
    output logic [N-1:0] rdata0,
    input  logic         req1,
    input  logic [5:0]   addr1,
    input  logic         lock1,
    output logic         gnt1,
    output logic         rvalid1,
    output logic [N-1:0] rdata1,
    output logic [5:0]   mem_addr,
    input  logic [N-1:0] mem_q
);
    typedef enum logic {ARB, LOCK1} state_t;

    state_t       state_q, state_d;
    logic         win1;
    logic         rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [N-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifdef IMEM_ARB_RR_EN
    logic         last_q, last_d;
`else
    logic [3:0]   run_cnt_q, run_cnt_d;
`endif

    always_comb begin
`ifdef IMEM_ARB_RR_EN
        // last_q == 0 means port 0 won last, so port 1 goes first on a tie
        win1 = req1 && (!req0 || !last_q);
`else
        win1 = req1 && (!req0 || run_cnt_q == 4'(MAXRUN));
`endif
        gnt1      = reset_n && (state_q == LOCK1 ? req1 : win1);
        gnt0      = reset_n && state_q == ARB && req0 && !win1;
        mem_addr  = gnt1 ? addr1 : gnt0 ? addr0 : 6'd0;
        state_d   = state_q == ARB ? ((gnt1 && lock1) ? LOCK1 : ARB) : (lock1 ? LOCK1 : ARB);
`ifdef IMEM_ARB_RR_EN
        last_d    = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
`else
        run_cnt_d = (state_q == LOCK1 || gnt1 || !req1) ? 4'd0 :
                    (gnt0 && run_cnt_q != 4'(MAXRUN)) ? run_cnt_q + 4'd1 : run_cnt_q;
`endif
        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        rdata0_d  = gnt0 ? mem_q : rdata0_q;
        rdata1_d  = gnt1 ? mem_q : rdata1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
`ifdef IMEM_ARB_RR_EN
            last_q    <= 1'b0;
`else
            run_cnt_q <= 4'd0;
`endif
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
`ifdef IMEM_ARB_RR_EN
            last_q    <= last_d;
`else
            run_cnt_q <= run_cnt_d;
`endif
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed stimulus; expected read data queued per port and checked by a monitor on rvalid.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, lock1;
    logic [5:0]  addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1, mem_q;
    logic [5:0]  mem_addr;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

`ifdef IMEM_ARB_RR_EN
    localparam int LOCK_WAIT = 0;
`else
    localparam int LOCK_WAIT = 4;
`endif

    imem_arbiter #(.N(32), .MAXRUN(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_q(mem_q)
    );

    assign mem_q = 32'hA5A50000 | {26'd0, mem_addr};
    always #5 clk = ~clk;

    function automatic logic [31:0] md(input logic [5:0] a);
        return 32'hA5A50000 | {26'd0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic gchk(input string name, input logic e0, input logic e1, input logic [5:0] ea);
        @(negedge clk);
        check({name, " gnt0"}, 32'(gnt0), 32'(e0));
        check({name, " gnt1"}, 32'(gnt1), 32'(e1));
        check({name, " mem_addr"}, 32'(mem_addr), 32'(ea));
        if (e0) q0.push_back(md(ea));
        if (e1) q1.push_back(md(ea));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rvalid0) begin
                    if (q0.size() == 0) check("rvalid0 unexpected", 32'(rvalid0), 32'd0);
                    else check("rdata0", rdata0, q0.pop_front());
                end
                if (rvalid1) begin
                    if (q1.size() == 0) check("rvalid1 unexpected", 32'(rvalid1), 32'd0);
                    else check("rdata1", rdata1, q1.pop_front());
                end
            end
        join_none
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0; addr0 = 6'd5; addr1 = 6'd7;
        repeat (2) @(negedge clk);
        check("rst gnt0", 32'(gnt0), 32'd0);
        check("rst gnt1", 32'(gnt1), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst rvalid0", 32'(rvalid0), 32'd0);
        check("rst rvalid1", 32'(rvalid1), 32'd0);
        check("rst rdata0", rdata0, 32'd0);
        check("rst rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef IMEM_ARB_RR_EN
        gchk("release", 1'b0, 1'b1, 6'd7);
`else
        gchk("release", 1'b1, 1'b0, 6'd5);
`endif
        req0 = 1'b0; req1 = 1'b0;
        gchk("idle", 1'b0, 1'b0, 6'd0);
        req0 = 1'b1; addr0 = 6'd3;
        gchk("single", 1'b1, 1'b0, 6'd3);
        req0 = 1'b0;
        gchk("single after", 1'b0, 1'b0, 6'd0);
        check("single rvalid0 drop", 32'(rvalid0), 32'd0);
        check("single rdata0 hold", rdata0, 32'hA5A50003);
        req0 = 1'b1; req1 = 1'b1; addr0 = 6'd20; addr1 = 6'd40;
        for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_RR_EN
            if (i % 2 == 0) gchk("rr", 1'b0, 1'b1, 6'd40);
            else gchk("rr", 1'b1, 1'b0, 6'd20);
`else
            if (i % 5 == 4) gchk("starve", 1'b0, 1'b1, 6'd40);
            else gchk("starve", 1'b1, 1'b0, 6'd20);
`endif
        end
        req0 = 1'b0; req1 = 1'b0;
        gchk("drain", 1'b0, 1'b0, 6'd0);
        req0 = 1'b1; addr0 = 6'd30; req1 = 1'b1; lock1 = 1'b1; addr1 = 6'd10;
        for (int i = 0; i < LOCK_WAIT; i++) gchk("lock wait", 1'b1, 1'b0, 6'd30);
        for (int i = 0; i < 4; i++) begin
            addr1 = 6'(10 + i);
            gchk("lock burst", 1'b0, 1'b1, addr1);
        end
        req1 = 1'b0; lock1 = 1'b0;
        gchk("lock exit", 1'b0, 1'b0, 6'd0);
        gchk("after lock", 1'b1, 1'b0, 6'd30);
        req0 = 1'b0;
        gchk("idle2", 1'b0, 1'b0, 6'd0);
        req1 = 1'b1; addr1 = 6'd9;
        @(negedge clk);
        check("midrst gnt1", 32'(gnt1), 32'd1);
        check("midrst mem_addr", 32'(mem_addr), 32'd9);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst gnt1 low", 32'(gnt1), 32'd0);
        check("midrst addr low", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        check("midrst rvalid1", 32'(rvalid1), 32'd0);
        check("midrst rdata1", rdata1, 32'd0);
        check("midrst rdata0", rdata0, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        gchk("post rst idle", 1'b0, 1'b0, 6'd0);
        gchk("post rst idle2", 1'b0, 1'b0, 6'd0);
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single combinational instruction memory (64 words, 6-bit word address) between the processor fetch path (port 0) and a debug/loader read path (port 1). Sits between both requesters and the imem read port. It grants at most one access per cycle, drives the memory address and returns registered read data to the winner. Port 1 can take a lock to stream a block of words without interleaving.

## Interface
- N, 32, data word width; must match the imem word width.
- MAXRUN, 4, consecutive port-0 grants tolerated while port 1 waits; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- req0  in  1  port 0 (fetch) request; held with addr0 stable until gnt0 is sampled high.
- addr0  in  6  port 0 word address.
- gnt0  out  1  port 0 granted this cycle.
- rvalid0  out  1  port 0 read data valid; single-cycle pulse.
- rdata0  out  N  port 0 read data.
- req1, addr1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (debug/loader).
- lock1  in  1  port 1 requests exclusive ownership; sampled together with gnt1.
- mem_addr  out  6  address to imem.
- mem_q  in  N  imem combinational read data.

## Operation
- Two-state FSM: ARB (normal arbitration) and LOCK1 (port 1 exclusive).
- ARB, fixed priority:
  - Default: port 0 wins.
  - Port 1 wins if req1 && !req0, or if req1 && run_cnt == MAXRUN.
- run_cnt (4 bits):
  - +1 on each cycle with gnt0 && req1.
  - Cleared on gnt1, or on any cycle with !req1.
  - Saturates at MAXRUN.
- ARB -> LOCK1 on a cycle with gnt1 && lock1.
- LOCK1:
  - gnt0 forced 0.
  - gnt1 = req1.
  - run_cnt held at 0.
  - LOCK1 -> ARB on any cycle with lock1 == 0. That cycle still arbitrates as LOCK1.
- Grants are mutually exclusive and never asserted without the matching req.
- mem_addr = addr of the granted port, else 6'd0.
- Response: on the edge after gntX, rdataX <= mem_q and rvalidX <= 1. Otherwise rvalidX <= 0 and rdataX holds its last value.
- No internal buffering. A requester that drops req before its grant loses nothing. A requester that changes addr while req is high and ungranted gets the new address.

## Timing
- gnt0, gnt1 and mem_addr are combinational from req/lock/addr and the registered state. There is no registered path through the grant.
- Read latency: 1 cycle from grant to rvalid. Back-to-back grants give one word per cycle per port.
- Simultaneous req0 and req1 in ARB with run_cnt < MAXRUN: port 0 is granted, run_cnt increments.
- Asynchronous reset values, effective immediately:
  - FSM = ARB, run_cnt = 0.
  - rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
  - gnt0 = gnt1 = 0 and mem_addr = 0 while reset_n is low.
- Reset asserted mid-access discards the pending response. The requester must re-request after release.
- First grant possible in the first cycle with reset_n high.

## Configuration
- IMEM_ARB_RR_EN defined:
  - ARB state uses round-robin. A 1-bit last-winner register (reset 0 = port 0) gives priority to the other port when both request.
  - run_cnt and MAXRUN are unused; run_cnt is tied to 0.
  - LOCK1 behaviour is unchanged.
- IMEM_ARB_RR_EN undefined: fixed priority with the starvation guard as above.

## Test plan
Bench imem model: mem_q = 32'hA5A50000 | addr.
- Reset: hold reset_n low with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_addr = 0. Release -> gnt0 = 1 in that same cycle.
- Single port: req0 with addr0 = 6'd3 for 1 cycle -> gnt0 = 1 and mem_addr = 3 that cycle. Next cycle rvalid0 = 1, rdata0 = 32'hA5A50003, then rvalid0 = 0 with rdata0 held.
- Starvation guard (macro undefined, MAXRUN = 4): req0 and req1 held continuously -> grant pattern is 4×gnt0, 1×gnt1, repeating.
- Round-robin (macro defined): same stimulus -> gnt0 and gnt1 alternate, starting with port 1 after reset.
- Lock: req1 + lock1 with addr1 = 10, 11, 12, 13 while req0 is held -> four consecutive gnt1 and rdata1 = 32'hA5A5000A..D. Drop lock1 with req1 low -> gnt0 on the next cycle.
- Reset mid-op: assert reset_n low in the cycle after gnt1 -> rvalid1 is never seen high, and rdata1 = 0.
